button_debounce: RTL and testbench

Input-side counterpart to the board LED blinker: takes a raw, bouncing push-button pin and turns it into clean, clock-synchronous events. It sits directly behind a top-level key pin, for example a board KEY on the 50 MHz clock. It provides:

- a debounced level;
- single-cycle press and release strobes;
- a long-press strobe;
- a wrapping press counter that board bring-up logic can drive LEDs from.

---
 rtl/button_debounce_pkg.sv | 15 +
 rtl/button_debounce_sync_2ff.sv | 25 ++
 rtl/button_debounce.sv | 136 +++++++++++++
 tb/tb_button_debounce.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_debounce_pkg.sv
// Shared board-utility types and default timing constants for push-button handling.
package button_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } button_state_t;

  // 10 ms and 1 s expressed in cycles of a 50 MHz board clock.
  localparam int DEB_10MS_50MHZ = 500_000;
  localparam int LONG_1S_50MHZ  = 50_000_000;

endpackage

// File: rtl/button_debounce_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous board input.
// RST_VAL lets each input reset to its idle pin level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronizes a raw key pin and produces a clean level,
// press/release/long-press strobes and a wrapping press counter.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// RELEASED     | button accepted as up, watching for a press
// PRESS_WAIT   | pin reads pressed, counting stable samples before accepting
// PRESSED      | button accepted as down, long-press timer running
// RELEASE_WAIT | pin reads released, counting stable samples before accepting
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEB_10MS_50MHZ,
  parameter int LONG_CYCLES     = LONG_1S_50MHZ,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int LW = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

  // Idle pin level, so reset release never looks like a press.
  localparam logic SYNC_RST = ACTIVE_LOW ? 1'b1 : 1'b0;

  button_state_t   state;
  logic [DW-1:0]   deb_ctr;
  logic [LW-1:0]   long_ctr;
  logic            long_done;
  logic            btn_sync;
  logic            p;
  logic            holding;
  logic            release_accept;
  logic            long_hit;

  sync_2ff #(
    .RST_VAL (SYNC_RST)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_in),
    .q     (btn_sync)
  );

  // Normalize polarity and decode long-press conditions for this cycle.
  always_comb begin
    p              = ACTIVE_LOW ? ~btn_sync : btn_sync;
    holding        = (state == PRESSED) || (state == RELEASE_WAIT);
    release_accept = (state == RELEASE_WAIT) && !p && (deb_ctr == DEB_LAST);
    // An accepted release wins over a long-press hit landing on the same edge,
    // keeping the strobes mutually exclusive.
    long_hit       = holding && (long_ctr == LONG_LAST) && !long_done && !release_accept;
  end

  // Debounce FSM, long-press timer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RELEASED;
      deb_ctr       <= '0;
      long_ctr      <= '0;
      long_done     <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;

      if (holding) begin
        if (long_ctr != LONG_LAST) begin
          long_ctr <= long_ctr + 1'b1;
        end
        if (long_hit) begin
          long_pulse <= 1'b1;
          long_done  <= 1'b1;
        end
      end

      unique case (state)
        RELEASED: begin
          if (p) begin
            state   <= PRESS_WAIT;
            deb_ctr <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!p) begin
            state <= RELEASED;
          end else if (deb_ctr == DEB_LAST) begin
            state       <= PRESSED;
            press_pulse <= 1'b1;
            btn_level   <= 1'b1;
            press_count <= press_count + 8'd1;
            long_ctr    <= '0;
            long_done   <= 1'b0;
          end else begin
            deb_ctr <= deb_ctr + 1'b1;
          end
        end
        PRESSED: begin
          if (!p) begin
            state   <= RELEASE_WAIT;
            deb_ctr <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (p) begin
            state <= PRESSED;
          end else if (release_accept) begin
            state         <= RELEASED;
            release_pulse <= 1'b1;
            btn_level     <= 1'b0;
          end else begin
            deb_ctr <= deb_ctr + 1'b1;
          end
        end
        default: begin
          state <= RELEASED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20,
// active-low pin. Stimulus pushes expected strobe events (kind, cycle, count,
// level) into a queue; a monitor pops one per observed strobe.
module tb_button_debounce;

  localparam int D = 4;
  localparam int L = 20;
  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;

  typedef struct packed {
    int         kind;
    int         cyc;
    logic [7:0] cnt;
    logic       lvl;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_in;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_count;

  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_count = 8'd0;
  ev_t        exp_q[$];

  button_debounce #(
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_in        (btn_in),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .press_count   (press_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1: the next edge is edge 0, the strobe shows after edge D+2.
  task automatic push_ev(input int kind, input int at, input logic [7:0] cnt, input logic lvl);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    e.cnt  = cnt;
    e.lvl  = lvl;
    exp_q.push_back(e);
  endtask

  task automatic do_press();
    btn_in    = 1'b0;
    exp_count = exp_count + 8'd1;
    push_ev(K_PRESS, cyc + 1 + D + 2, exp_count, 1'b1);
  endtask

  task automatic do_release();
    btn_in = 1'b1;
    push_ev(K_RELEASE, cyc + 1 + D + 2, exp_count, 1'b0);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    btn_in = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (rst_n && (press_pulse || release_pulse || long_pulse)) begin
          int   k;
          int   n;
          ev_t  e;
          n = int'(press_pulse) + int'(release_pulse) + int'(long_pulse);
          checks++;
          if (n != 1) begin
            failures++;
            $display("FAIL strobe_exclusive: got %0d strobes at cycle %0d, want 1", n, cyc);
          end
          k = press_pulse ? K_PRESS : (release_pulse ? K_RELEASE : K_LONG);
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_strobe: got kind=%0d at cycle %0d, want none", k, cyc);
          end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.cnt !== press_count || e.lvl !== btn_level) begin
              failures++;
              $display("FAIL strobe_event: got kind=%0d cyc=%0d count=%0d level=%0b, want kind=%0d cyc=%0d count=%0d level=%0b",
                       k, cyc, press_count, btn_level, e.kind, e.cyc, e.cnt, e.lvl);
            end
          end
        end
      end
    join_none

    // Reset state
    tick(3);
    chk("reset_level", {7'd0, btn_level}, 8'd0);
    chk("reset_count", press_count, 8'd0);
    chk("reset_strobes", {5'd0, press_pulse, release_pulse, long_pulse}, 8'd0);
    rst_n = 1'b1;
    tick(3);

    // 1. Clean press, then release
    do_press();
    tick(10);
    chk("clean_level", {7'd0, btn_level}, 8'd1);
    chk("clean_count", press_count, 8'd1);
    do_release();
    tick(10);
    chk("clean_rel_level", {7'd0, btn_level}, 8'd0);

    // 2. Bounce: 2 cycles pressed / 2 released, never long enough to accept
    for (int i = 0; i < 5; i++) begin
      btn_in = 1'b0;
      tick(2);
      btn_in = 1'b1;
      tick(2);
    end
    tick(10);
    chk("bounce_level", {7'd0, btn_level}, 8'd0);
    chk("bounce_count", press_count, exp_count);

    // 3. Release glitch of 3 cycles is rejected; later stable release accepted
    do_press();
    tick(9);
    btn_in = 1'b1;
    tick(3);
    btn_in = 1'b0;
    tick(4);
    chk("glitch_level", {7'd0, btn_level}, 8'd1);
    do_release();
    tick(10);

    // 4. Long press: one long strobe after edge D+2+L, single release after
    push_ev(K_LONG, cyc + 1 + D + 2 + L, exp_count + 8'd1, 1'b1);
    do_press();
    // The press entry must come first in the queue.
    begin
      ev_t a;
      ev_t b;
      a = exp_q.pop_back();
      b = exp_q.pop_back();
      exp_q.push_back(a);
      exp_q.push_back(b);
    end
    tick(40);
    do_release();
    tick(40);
    chk("long_count", press_count, 8'd3);

    // 6. Reset while pressed, button held through deassertion
    do_press();
    tick(10);
    chk("pre_reset_level", {7'd0, btn_level}, 8'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_level", {7'd0, btn_level}, 8'd0);
    chk("midreset_count", press_count, 8'd0);
    chk("midreset_strobes", {5'd0, press_pulse, release_pulse, long_pulse}, 8'd0);
    tick(2);
    exp_count = 8'd1;
    rst_n = 1'b1;
    push_ev(K_PRESS, cyc + 1 + D + 2, exp_count, 1'b1);
    tick(10);
    chk("postreset_count", press_count, 8'd1);
    do_release();
    tick(10);

    // 5. Wrap: 255 more presses bring the count back to 0, the next gives 1
    for (int i = 0; i < 255; i++) begin
      do_press();
      tick(8);
      do_release();
      tick(8);
    end
    chk("wrap_zero", press_count, 8'd0);
    do_press();
    tick(10);
    chk("wrap_one", press_count, 8'd1);
    do_release();
    tick(10);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_strobes: got %0d unmatched expected events, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
